instr_fetch_unit: RTL and testbench

Parametrised multicycle instruction fetch unit for the processor datapath. It owns the PC, reads one instruction of INSTR_BYTES bytes over a narrow, wait-capable memory port, assembles the instruction, and hands it to the control unit over a valid/ready handshake. It replaces the fixed 8-bit, 4-byte irwrite sequencing in the controller FSM and adds memory wait states, branch/jump redirect with abort, and optional alignment faulting.

---
 rtl/instr_fetch_unit_if.sv | 26 ++
 rtl/instr_fetch_unit.sv | 147 ++++++++++++++
 tb/tb_instr_fetch_unit.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_fetch_unit_if.sv
// Bundles the narrow memory read port and the instruction valid/ready handshake of instr_fetch_unit.
// The master side is the fetch unit; the slave side is the memory plus the consumer of instructions.
interface instr_fetch_unit_if #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned INSTR_BYTES = 4
);
  logic                              mem_read;
  logic [ADDR_WIDTH-1:0]             mem_adr;
  logic                              mem_ready;
  logic [DATA_WIDTH-1:0]             mem_data;
  logic [DATA_WIDTH*INSTR_BYTES-1:0] instr;
  logic [ADDR_WIDTH-1:0]             instr_pc;
  logic                              instr_valid;
  logic                              instr_ready;

  modport master (
    output mem_read, mem_adr, instr, instr_pc, instr_valid,
    input  mem_ready, mem_data, instr_ready
  );

  modport slave (
    input  mem_read, mem_adr, instr, instr_pc, instr_valid,
    output mem_ready, mem_data, instr_ready
  );
endinterface

// File: rtl/instr_fetch_unit.sv
// Multicycle instruction fetch: owns the PC, assembles INSTR_BYTES lanes from a wait-capable byte port.
// Optional alignment faulting on redirect is enabled by defining IFU_ALIGN_CHECK_EN.
module instr_fetch_unit #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned INSTR_BYTES = 4,
  parameter int unsigned RESET_PC    = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  instr_fetch_unit_if.master    bus,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic [ADDR_WIDTH-1:0] pcvalue,
  output logic [INSTR_BYTES-1:0] irwrite,
  output logic                  busy,
  output logic                  fault
);

  localparam int unsigned CNT_W = $clog2(INSTR_BYTES);
  localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(INSTR_BYTES - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
`ifdef IFU_ALIGN_CHECK_EN
    , FAULT
`endif
  } state_t;

  state_t state, state_next;

  logic [CNT_W-1:0]                  cnt;
  logic [DATA_WIDTH*INSTR_BYTES-1:0] instr_q;
  logic [ADDR_WIDTH-1:0]             instr_pc_q;

  logic misaligned;
  logic redirect_ok;
  logic load_pc;
  logic capture;
  logic advance;

`ifdef IFU_ALIGN_CHECK_EN
  logic fault_q;
  logic set_fault;

  assign misaligned = |redirect_pc[CNT_W-1:0];
  assign fault      = fault_q;
`else
  assign misaligned = 1'b0;
  assign fault      = 1'b0;
`endif

  assign redirect_ok = redirect && !misaligned;

  // NOTE: non-blocking assignments for every register so all state updates see pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    state_next = state;
    load_pc    = 1'b0;
    capture    = 1'b0;
    advance    = 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
    set_fault  = 1'b0;
`endif
    case (state)
      IDLE: begin
        state_next = FETCH;
        load_pc    = redirect_ok;
      end
      FETCH: begin
        if (redirect_ok) begin
          load_pc = 1'b1;
        end else if (bus.mem_ready) begin
          capture = 1'b1;
          if (cnt == LAST_LANE) state_next = HOLD;
        end
      end
      HOLD: begin
        if (redirect_ok) begin
          load_pc    = 1'b1;
          state_next = FETCH;
        end else if (bus.instr_ready) begin
          advance    = 1'b1;
          state_next = FETCH;
        end
      end
      default: state_next = state;
    endcase
`ifdef IFU_ALIGN_CHECK_EN
    // A misaligned target freezes the unit; any byte or handshake in that cycle is abandoned.
    if (redirect && misaligned && state != FAULT) begin
      state_next = FAULT;
      set_fault  = 1'b1;
      capture    = 1'b0;
      advance    = 1'b0;
    end
`endif
  end

  // NOTE: the instruction register is reset too, since instr must read 0 out of reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pcvalue    <= ADDR_WIDTH'(RESET_PC);
      cnt        <= '0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else if (load_pc) begin
      pcvalue <= redirect_pc;
      cnt     <= '0;
    end else if (advance) begin
      pcvalue <= pcvalue + ADDR_WIDTH'(INSTR_BYTES);
      cnt     <= '0;
    end else if (capture) begin
      instr_q[DATA_WIDTH*cnt +: DATA_WIDTH] <= bus.mem_data;
      if (cnt == LAST_LANE) begin
        instr_pc_q <= pcvalue;
        cnt        <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

`ifdef IFU_ALIGN_CHECK_EN
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)         fault_q <= 1'b0;
    else if (set_fault) fault_q <= 1'b1;
  end
`endif

  // Request-side outputs decode registered state only, never an input.
  assign busy            = (state == FETCH);
  assign bus.mem_read    = busy;
  assign bus.mem_adr     = busy ? pcvalue + ADDR_WIDTH'(cnt) : '0;
  assign bus.instr_valid = (state == HOLD);
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign irwrite         = capture ? (INSTR_BYTES'(1) << cnt) : '0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: byte memory returns address+0x10, expected values hand-computed.
// Covers reset, wait states, redirect abort, handshake+redirect, stall hold, PC wrap, async reset, alignment.
module tb_instr_fetch_unit;
  localparam int DW = 8;
  localparam int AW = 8;
  localparam int IB = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          redirect = 1'b0;
  logic [AW-1:0] redirect_pc = '0;
  logic [AW-1:0] pcvalue;
  logic [IB-1:0] irwrite;
  logic          busy;
  logic          fault;

  int n_cmp = 0;
  int n_bad = 0;

  instr_fetch_unit_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INSTR_BYTES(IB)) bus ();

  instr_fetch_unit #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INSTR_BYTES(IB), .RESET_PC(0)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .pcvalue(pcvalue),
    .irwrite(irwrite),
    .busy(busy),
    .fault(fault)
  );

  always #5 clk = ~clk;

  // Memory image: byte at address a is a+0x10.
  assign bus.mem_data = bus.mem_adr + 8'h10;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string phase);
    check({phase, " mem_read"},    64'(bus.mem_read),    64'd0);
    check({phase, " mem_adr"},     64'(bus.mem_adr),     64'd0);
    check({phase, " instr"},       64'(bus.instr),       64'd0);
    check({phase, " instr_pc"},    64'(bus.instr_pc),    64'd0);
    check({phase, " instr_valid"}, 64'(bus.instr_valid), 64'd0);
    check({phase, " irwrite"},     64'(irwrite),         64'd0);
    check({phase, " busy"},        64'(busy),            64'd0);
    check({phase, " fault"},       64'(fault),           64'd0);
    check({phase, " pcvalue"},     64'(pcvalue),         64'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.mem_ready   = 1'b1;
    bus.instr_ready = 1'b1;

    // Reset state
    #12;
    check_reset_values("reset");
    @(negedge clk);
    reset = 1'b1;

    // Zero-wait fetch of 0x00..0x03
    step();
    check("c0 busy",    64'(busy),         64'd1);
    check("c0 mem_read", 64'(bus.mem_read), 64'd1);
    check("c0 mem_adr", 64'(bus.mem_adr),  64'h00);
    check("c0 irwrite", 64'(irwrite),      64'b0001);
    step();
    check("c1 mem_adr", 64'(bus.mem_adr),  64'h01);
    check("c1 irwrite", 64'(irwrite),      64'b0010);
    step();
    check("c2 irwrite", 64'(irwrite),      64'b0100);
    step();
    check("c3 mem_adr", 64'(bus.mem_adr),  64'h03);
    check("c3 irwrite", 64'(irwrite),      64'b1000);
    step();
    check("c4 instr_valid", 64'(bus.instr_valid), 64'd1);
    check("c4 instr",       64'(bus.instr),       64'h13121110);
    check("c4 instr_pc",    64'(bus.instr_pc),    64'h00);
    check("c4 mem_read",    64'(bus.mem_read),    64'd0);
    check("c4 busy",        64'(busy),            64'd0);

    // Back-to-back second instruction at 0x04
    step();
    check("c5 pcvalue", 64'(pcvalue),     64'h04);
    check("c5 mem_adr", 64'(bus.mem_adr), 64'h04);
    step(); step(); step();
    check("c8 instr_valid", 64'(bus.instr_valid), 64'd0);
    step();
    check("c9 instr_valid", 64'(bus.instr_valid), 64'd1);
    check("c9 instr",       64'(bus.instr),       64'h17161514);
    check("c9 instr_pc",    64'(bus.instr_pc),    64'h04);

    // Fetch at 0x08 with mem_ready low for three cycles on lane 2
    step();
    check("c10 mem_adr", 64'(bus.mem_adr), 64'h08);
    step();
    step();
    bus.mem_ready = 1'b0;
    #1;
    check("wait0 mem_adr", 64'(bus.mem_adr), 64'h0A);
    check("wait0 irwrite", 64'(irwrite),     64'd0);
    step();
    check("wait1 mem_adr", 64'(bus.mem_adr), 64'h0A);
    step();
    check("wait2 mem_adr", 64'(bus.mem_adr), 64'h0A);
    check("wait2 mem_read", 64'(bus.mem_read), 64'd1);
    step();
    bus.mem_ready = 1'b1;
    #1;
    check("wait end mem_adr", 64'(bus.mem_adr), 64'h0A);
    check("wait end irwrite", 64'(irwrite),     64'b0100);
    step();
    check("c16 instr_valid", 64'(bus.instr_valid), 64'd0);
    check("c16 mem_adr",     64'(bus.mem_adr),     64'h0B);
    step();
    bus.instr_ready = 1'b0;
    check("c17 instr_valid", 64'(bus.instr_valid), 64'd1);
    check("c17 instr",       64'(bus.instr),       64'h1B1A1918);
    check("c17 instr_pc",    64'(bus.instr_pc),    64'h08);

    // Consumer stalls for 10 cycles: instruction held
    for (int i = 0; i < 10; i++) begin
      step();
      check("stall instr",       64'(bus.instr),       64'h1B1A1918);
      check("stall instr_valid", 64'(bus.instr_valid), 64'd1);
      check("stall mem_read",    64'(bus.mem_read),    64'd0);
    end

    // Handshake and redirect to 0x20 in the same HOLD cycle
    bus.instr_ready = 1'b1;
    redirect        = 1'b1;
    redirect_pc     = 8'h20;
    step();
    redirect = 1'b0;
    check("hs+redir mem_adr",     64'(bus.mem_adr),     64'h20);
    check("hs+redir pcvalue",     64'(pcvalue),         64'h20);
    check("hs+redir instr_valid", 64'(bus.instr_valid), 64'd0);

    // Redirect to 0x40 after two lanes captured; the byte in that cycle is dropped
    step();
    step();
    check("pre-redir mem_adr", 64'(bus.mem_adr), 64'h22);
    redirect    = 1'b1;
    redirect_pc = 8'h40;
    #1;
    check("redir irwrite", 64'(irwrite), 64'd0);
    step();
    redirect = 1'b0;
    check("redir mem_adr", 64'(bus.mem_adr), 64'h40);
    check("redir pcvalue", 64'(pcvalue),     64'h40);
    step(); step(); step(); step();
    check("redir instr_valid", 64'(bus.instr_valid), 64'd1);
    check("redir instr",       64'(bus.instr),       64'h53525150);
    check("redir instr_pc",    64'(bus.instr_pc),    64'h40);

    // PC wrap: fetch 0xFC..0xFF then advance to 0x00
    redirect    = 1'b1;
    redirect_pc = 8'hFC;
    step();
    redirect = 1'b0;
    check("wrap adr FC", 64'(bus.mem_adr), 64'hFC);
    step();
    check("wrap adr FD", 64'(bus.mem_adr), 64'hFD);
    step();
    check("wrap adr FE", 64'(bus.mem_adr), 64'hFE);
    step();
    check("wrap adr FF", 64'(bus.mem_adr), 64'hFF);
    step();
    check("wrap instr",    64'(bus.instr),    64'h0F0E0D0C);
    check("wrap instr_pc", 64'(bus.instr_pc), 64'hFC);
    step();
    check("wrap pcvalue", 64'(pcvalue),     64'h00);
    check("wrap mem_adr", 64'(bus.mem_adr), 64'h00);
    check("wrap busy",    64'(busy),        64'd1);

    // Asynchronous reset mid-fetch
    step();
    #3;
    reset = 1'b0;
    #1;
    check_reset_values("async reset");
    @(negedge clk);
    reset = 1'b1;
    step();
    check("post-reset mem_adr", 64'(bus.mem_adr), 64'h00);

    // Misaligned redirect to 0x41
    redirect    = 1'b1;
    redirect_pc = 8'h41;
    step();
    redirect = 1'b0;
`ifdef IFU_ALIGN_CHECK_EN
    check("align fault",    64'(fault),        64'd1);
    check("align mem_read", 64'(bus.mem_read), 64'd0);
    check("align busy",     64'(busy),         64'd0);
    redirect    = 1'b1;
    redirect_pc = 8'h40;
    for (int i = 0; i < 6; i++) begin
      step();
      check("fault instr_valid", 64'(bus.instr_valid), 64'd0);
      check("fault mem_read",    64'(bus.mem_read),    64'd0);
      check("fault sticky",      64'(fault),           64'd1);
    end
    redirect = 1'b0;
`else
    check("unaligned fault",    64'(fault),        64'd0);
    check("unaligned mem_adr",  64'(bus.mem_adr),  64'h41);
    check("unaligned mem_read", 64'(bus.mem_read), 64'd1);
    step(); step(); step(); step();
    check("unaligned instr_valid", 64'(bus.instr_valid), 64'd1);
    check("unaligned instr",       64'(bus.instr),       64'h54535251);
    check("unaligned instr_pc",    64'(bus.instr_pc),    64'h41);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
